// File: rtl/seg7_scan.sv
// Time-multiplexed hex display driver: scans N_DIGITS digits on each scan_tick,
// latches inputs once per frame, blanks anodes between digits, suppresses leading zeros.
module seg7_scan #(
  parameter int N_DIGITS     = 8,
  parameter int BLANK_CYCLES = 4,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_tick,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES);

  // abcdefg pattern, bit0 = a, 1 = segment on
  function automatic logic [6:0] hexdec(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;  4'h1: pat = 7'h06;  4'h2: pat = 7'h5B;  4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;  4'h5: pat = 7'h6D;  4'h6: pat = 7'h7D;  4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;  4'h9: pat = 7'h6F;  4'hA: pat = 7'h77;  4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;  4'hD: pat = 7'h5E;  4'hE: pat = 7'h79;  4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         r_blank_cnt;
  logic [4*N_DIGITS-1:0] r_value_sh;
  logic [N_DIGITS-1:0]   r_dp_sh;
  logic [N_DIGITS-1:0]   r_en_sh;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  r_frame_done;

  logic                  w_latch;
  logic [N_DIGITS-1:0]   w_upper_zero;
  logic [3:0]            w_nib;
  logic                  w_dark;
  logic [N_DIGITS-1:0]   w_an;
  logic [6:0]            w_seg;
  logic                  w_dp;

  assign w_latch = scan_tick && (r_idx == LAST_IDX);

  // w_upper_zero[i]: nibbles i..N_DIGITS-1 of the shadow value are all zero
  always_comb begin
    logic w_acc;
    w_acc = 1'b1;
    w_upper_zero = {N_DIGITS{1'b0}};
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_acc = w_acc && (r_value_sh[4*i +: 4] == 4'h0);
      w_upper_zero[i] = w_acc;
    end
  end

  always_comb begin
    w_nib  = r_value_sh[{r_idx, 2'b00} +: 4];
    w_dark = (r_blank_cnt != {CW{1'b0}}) || !r_en_sh[r_idx] ||
             ((LZ_SUPPRESS != 0) && (r_idx != {IW{1'b0}}) && w_upper_zero[r_idx]);
    w_an   = {N_DIGITS{1'b1}};
    if (w_dark) begin
      w_seg = 7'h7F;
      w_dp  = 1'b1;
    end else begin
      w_an[r_idx] = 1'b0;
      w_seg       = ~hexdec(w_nib);
      w_dp        = ~r_dp_sh[r_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= LAST_IDX;
      r_blank_cnt  <= {CW{1'b0}};
      r_value_sh   <= {(4*N_DIGITS){1'b0}};
      r_dp_sh      <= {N_DIGITS{1'b0}};
      r_en_sh      <= {N_DIGITS{1'b0}};
      r_an         <= {N_DIGITS{1'b1}};
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      // a tick during blanking simply restarts the blank count
      if (scan_tick) begin
        r_idx       <= (r_idx == LAST_IDX) ? {IW{1'b0}} : r_idx + IW'(1'b1);
        r_blank_cnt <= BLANK_LD;
      end else if (r_blank_cnt != {CW{1'b0}}) begin
        r_blank_cnt <= r_blank_cnt - CW'(1'b1);
      end else begin
        r_blank_cnt <= r_blank_cnt;
      end
      if (w_latch) begin
        r_value_sh <= value;
        r_dp_sh    <= dp_in;
        r_en_sh    <= digit_en;
      end else begin
        r_value_sh <= r_value_sh;
        r_dp_sh    <= r_dp_sh;
        r_en_sh    <= r_en_sh;
      end
      r_frame_done <= w_latch;
      r_an         <= w_an;
      r_seg        <= w_seg;
      r_dp         <= w_dp;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule
